movement_probe_scheduler: RTL and testbench
===========================================

# movement_probe_scheduler

Per-frame sequencer for the player-character movement datapath. Once per frame it issues four collision probes around the character's bounding box over one shared tile-collision lookup port. It collects the results, then presents the four registered blocked flags together with a one-cycle `move_enable` pulse to the character movement block. It sits between the frame timing generator, the tile-map collision lookup and the character movement block.

## Interface
- `CHAR_W`, default 8: character width in pixels.
- `CHAR_H`, default 16: character height in pixels.
- `TIMEOUT`, default 15: maximum wait cycles per probe before forcing a result. Legal range 1..255.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse per frame start.
- `x_position`  in  8  character x, pixels.
- `y_position`  in  8  character y, pixels.
- `probe_req`  out  1  probe request (valid).
- `probe_x`  out  8  probe pixel x.
- `probe_y`  out  8  probe pixel y.
- `probe_ack`  in  1  probe accepted; `probe_solid` valid this cycle.
- `probe_solid`  in  1  1 = probed pixel is solid.
- `down_blocked`, `up_blocked`, `left_blocked`, `right_blocked`  out  1 each  registered collision flags.
- `move_enable`  out  1  one-cycle pulse: flags updated, movement may step.
- `busy`  out  1  high in any non-IDLE state.
- `overrun`  out  1  one-cycle pulse: a `frame_tick` was dropped.
- `timeout`  out  1  one-cycle pulse: a probe was forced solid.

## Operation
- States: IDLE, PROBE_D, PROBE_U, PROBE_L, PROBE_R, COMMIT.
- **IDLE:**
  - On `frame_tick`, capture `x_position` and `y_position` into `xs` and `ys`.
  - Clear the shadow flags and go to PROBE_D.
- **Probe coordinates,** computed from `xs`/`ys`. All sums are 8-bit and wrap mod 256; no saturation.
  - D: (`xs`+`CHAR_W`/2, `ys`+`CHAR_H`).
  - U: (`xs`+`CHAR_W`/2, `ys`−1).
  - L: (`xs`−1, `ys`+`CHAR_H`/2).
  - R: (`xs`+`CHAR_W`, `ys`+`CHAR_H`/2).
- **Handshake:**
  - `probe_req` is high in exactly the four PROBE states. `probe_x`/`probe_y` are stable while it is high.
  - A cycle with `probe_req`&`probe_ack` completes one transaction. `probe_solid` is captured into that direction's shadow flag and the FSM advances D→U→L→R→COMMIT.
  - `probe_req` may stay high across back-to-back probes with a new address. The responder counts transactions, not edges.
  - `probe_ack` while `probe_req` is low is ignored.
- **Timeout:**
  - The wait counter clears on entry to each PROBE state.
  - If `TIMEOUT` consecutive cycles pass with no ack, the shadow flag is set to 1 and the FSM advances. `timeout` pulses the following cycle.
  - An ack in the `TIMEOUT`-th cycle is a normal completion.
- **COMMIT:** one cycle. On its exit edge all four outputs load from the shadow flags simultaneously, `move_enable` goes high for one cycle, and the FSM returns to IDLE.
- **Overrun:** a `frame_tick` in any non-IDLE state is dropped. `overrun` pulses the next cycle and the current sequence continues unaffected.
- A `frame_tick` in the IDLE cycle where `move_enable` is high is accepted normally.
- Position inputs are ignored outside the capture edge.

## Timing
- **Reset** (async assert, state in IDLE):
  - Blocked flags = 1, so the character holds position until the first commit.
  - `move_enable`, `busy`, `overrun`, `timeout`, `probe_req` = 0; `probe_x`/`probe_y` = 0; the wait counter and shadow flags are cleared.
- **Reset mid-sequence:** aborts immediately. No `move_enable` is produced and the flags return to 1.
- **Latency with zero-wait acks**, tick high in cycle 0:
  - Probes occupy cycles 1–4 (D, U, L, R).
  - COMMIT is cycle 5.
  - Flags update and `move_enable` is high in cycle 6.
  - `busy` is high in cycles 1–5.
- Each wait cycle adds one cycle. Worst case is tick + 4×`TIMEOUT` + 2 cycles.
- All outputs are registered except `probe_req`/`probe_x`/`probe_y`, which decode from state and the held position.

## Test plan
- **Zero-wait, no collision:** reset, x=72, y=60, tick, ack every cycle with solid=0.
  - Probes (76,76), (76,59), (71,68), (80,68).
  - `move_enable` in cycle 6; all flags 0.
- **Mixed results with waits:** solid pattern D=1, U=0, L=1, R=0, ack delayed 3 cycles each.
  - Flags D=1, U=0, L=1, R=0, applied together.
  - `move_enable` in cycle 18.
- **Wrap-around:** x=0, y=250.
  - L probe x = 255.
  - D probe y = 10 (250+16 mod 256).
  - U probe y = 249.
- **Timeout:** never ack the U probe, `TIMEOUT`=15.
  - U req held 15 cycles, `timeout` pulses once, `up_blocked`=1.
  - The remaining probes complete; exactly one `move_enable`.
- **Overrun and back-to-back:**
  - A tick at cycle 3 → `overrun` pulses at cycle 4, a single `move_enable` at cycle 6.
  - A tick at cycle 6 → a new sequence starts at cycle 7.
- **Reset mid-probe:** deassert `resetn` during PROBE_L.
  - Immediately `probe_req`=0 and all flags=1.
  - No `move_enable`; after release the FSM is IDLE.

Source files
------------

// File: rtl/movement_probe_scheduler.sv
// movement_probe_scheduler: once per frame, probes four points around the character box and commits the blocked flags.
// Latency: with immediate acks, tick in cycle 0 -> probes in cycles 1-4, COMMIT in 5, flags + move_enable in cycle 6.
// Backpressure: probe_req is held until probe_ack or TIMEOUT idle cycles; a frame_tick while busy is dropped and reported.
module movement_probe_scheduler #(
    parameter int CHAR_W  = 8,
    parameter int CHAR_H  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    output logic       probe_req,
    output logic [7:0] probe_x,
    output logic [7:0] probe_y,
    input  logic       probe_ack,
    input  logic       probe_solid,
    output logic       down_blocked,
    output logic       up_blocked,
    output logic       left_blocked,
    output logic       right_blocked,
    output logic       move_enable,
    output logic       busy,
    output logic       overrun,
    output logic       timeout
);

    // Probe states are consecutive so "advance" is state + 1 and the
    // direction index (D=0, U=1, L=2, R=3) is state - 1.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROBE_D = 3'd1,
        PROBE_U = 3'd2,
        PROBE_L = 3'd3,
        PROBE_R = 3'd4,
        COMMIT  = 3'd5
    } state_t;

    localparam logic [7:0] HALF_W  = 8'(CHAR_W / 2);
    localparam logic [7:0] HALF_H  = 8'(CHAR_H / 2);
    localparam logic [7:0] FULL_W  = 8'(CHAR_W);
    localparam logic [7:0] FULL_H  = 8'(CHAR_H);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] xs_q, xs_d;
    logic [7:0] ys_q, ys_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] shadow_q, shadow_d;   // bit0 down, bit1 up, bit2 left, bit3 right
    logic [3:0] flags_q, flags_d;
    logic       move_enable_q, move_enable_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       timeout_q, timeout_d;
    logic [1:0] dir;

    // Probe address decodes from state and the captured position; all sums wrap mod 256.
    always_comb begin
        probe_req = 1'b0;
        probe_x   = 8'd0;
        probe_y   = 8'd0;
        case (state_q)
            PROBE_D: begin
                probe_req = 1'b1;
                probe_x   = xs_q + HALF_W;
                probe_y   = ys_q + FULL_H;
            end
            PROBE_U: begin
                probe_req = 1'b1;
                probe_x   = xs_q + HALF_W;
                probe_y   = ys_q - 8'd1;
            end
            PROBE_L: begin
                probe_req = 1'b1;
                probe_x   = xs_q - 8'd1;
                probe_y   = ys_q + HALF_H;
            end
            PROBE_R: begin
                probe_req = 1'b1;
                probe_x   = xs_q + FULL_W;
                probe_y   = ys_q + HALF_H;
            end
            default: begin
                probe_req = 1'b0;
            end
        endcase
    end

    // Sequencer next-state: capture, probe handshake with timeout, commit, overrun detection.
    always_comb begin
        state_d       = state_q;
        xs_d          = xs_q;
        ys_d          = ys_q;
        wait_d        = wait_q;
        shadow_d      = shadow_q;
        flags_d       = flags_q;
        move_enable_d = 1'b0;
        overrun_d     = 1'b0;
        timeout_d     = 1'b0;
        dir           = 2'(state_q - 3'd1);
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    xs_d     = x_position;
                    ys_d     = y_position;
                    shadow_d = 4'b0000;
                    wait_d   = 8'd0;
                    state_d  = PROBE_D;
                end
            end
            PROBE_D, PROBE_U, PROBE_L, PROBE_R: begin
                // An ack on the last allowed wait cycle still wins over the timeout.
                if (probe_ack) begin
                    shadow_d[dir] = probe_solid;
                    wait_d        = 8'd0;
                    state_d       = state_t'(state_q + 3'd1);
                end else if (wait_q == TO_LAST) begin
                    shadow_d[dir] = 1'b1;
                    wait_d        = 8'd0;
                    timeout_d     = 1'b1;
                    state_d       = state_t'(state_q + 3'd1);
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            COMMIT: begin
                flags_d       = shadow_q;
                move_enable_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (frame_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset blocks all directions until the first commit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            xs_q          <= 8'd0;
            ys_q          <= 8'd0;
            wait_q        <= 8'd0;
            shadow_q      <= 4'b0000;
            flags_q       <= 4'b1111;
            move_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            wait_q        <= wait_d;
            shadow_q      <= shadow_d;
            flags_q       <= flags_d;
            move_enable_q <= move_enable_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign down_blocked  = flags_q[0];
    assign up_blocked    = flags_q[1];
    assign left_blocked  = flags_q[2];
    assign right_blocked = flags_q[3];
    assign move_enable   = move_enable_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_movement_probe_scheduler.sv
// tb_movement_probe_scheduler: directed frames against a frame-level behavioural model plus literal checks.
// Latency: checks every cycle on the falling edge; model advances one cycle per falling edge.
// Backpressure: responder delays or withholds acks per direction to exercise waits and timeouts.
module tb_movement_probe_scheduler;

    localparam int CW = 8;
    localparam int CH = 16;
    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] x_position = 8'd0;
    logic [7:0] y_position = 8'd0;
    logic       probe_ack = 1'b0;
    logic       probe_solid = 1'b0;
    logic       probe_req;
    logic [7:0] probe_x;
    logic [7:0] probe_y;
    logic       down_blocked, up_blocked, left_blocked, right_blocked;
    logic       move_enable, busy, overrun, timeout;

    int vectors = 0;
    int miscompares = 0;

    movement_probe_scheduler #(.CHAR_W(CW), .CHAR_H(CH), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .x_position   (x_position),
        .y_position   (y_position),
        .probe_req    (probe_req),
        .probe_x      (probe_x),
        .probe_y      (probe_y),
        .probe_ack    (probe_ack),
        .probe_solid  (probe_solid),
        .down_blocked (down_blocked),
        .up_blocked   (up_blocked),
        .left_blocked (left_blocked),
        .right_blocked(right_blocked),
        .move_enable  (move_enable),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_idx: -1 idle, 0..3 probing direction D,U,L,R, 4 commit.
    int m_idx;
    int m_wcnt;
    int m_px[4];
    int m_py[4];
    bit m_sh[4];
    bit m_fl[4];
    bit m_me, m_ov, m_to;

    task automatic model_reset();
        m_idx  = -1;
        m_wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 1'b0;
            m_fl[i] = 1'b1;
            m_px[i] = 0;
            m_py[i] = 0;
        end
        m_me = 1'b0;
        m_ov = 1'b0;
        m_to = 1'b0;
    endtask

    task automatic model_step();
        bit n_me, n_ov, n_to;
        int xs, ys;
        n_me = 1'b0;
        n_ov = 1'b0;
        n_to = 1'b0;
        if (m_idx == -1) begin
            if (frame_tick) begin
                xs = int'(x_position);
                ys = int'(y_position);
                m_px[0] = (xs + CW / 2) % 256;  m_py[0] = (ys + CH) % 256;
                m_px[1] = (xs + CW / 2) % 256;  m_py[1] = (ys + 255) % 256;
                m_px[2] = (xs + 255) % 256;     m_py[2] = (ys + CH / 2) % 256;
                m_px[3] = (xs + CW) % 256;      m_py[3] = (ys + CH / 2) % 256;
                for (int i = 0; i < 4; i++) m_sh[i] = 1'b0;
                m_idx  = 0;
                m_wcnt = 0;
            end
        end else begin
            if (frame_tick) n_ov = 1'b1;
            if (m_idx == 4) begin
                for (int i = 0; i < 4; i++) m_fl[i] = m_sh[i];
                n_me  = 1'b1;
                m_idx = -1;
            end else if (probe_ack) begin
                m_sh[m_idx] = probe_solid;
                m_idx++;
                m_wcnt = 0;
            end else if (m_wcnt + 1 >= TO) begin
                m_sh[m_idx] = 1'b1;
                m_idx++;
                m_wcnt = 0;
                n_to = 1'b1;
            end else begin
                m_wcnt++;
            end
        end
        m_me = n_me;
        m_ov = n_ov;
        m_to = n_to;
    endtask

    initial model_reset();

    // Per-cycle comparison of all outputs against the model, then advance the model.
    always @(negedge clock) begin
        logic exp_req;
        if (!resetn) model_reset();
        exp_req = (m_idx >= 0) && (m_idx < 4);
        check("outputs",
              {55'd0, probe_req, down_blocked, up_blocked, left_blocked, right_blocked,
               move_enable, busy, overrun, timeout},
              {55'd0, exp_req, m_fl[0], m_fl[1], m_fl[2], m_fl[3],
               m_me, (m_idx != -1), m_ov, m_to});
        if (exp_req)
            check("probe_xy", {48'd0, probe_x, probe_y}, {48'd0, 8'(m_px[m_idx]), 8'(m_py[m_idx])});
        if (resetn) model_step();
    end

    // ---------------- responder ----------------
    int resp_delay = 0;
    bit resp_solid[4];
    bit resp_never[4];

    always @(posedge clock) begin
        #1;
        if ((m_idx >= 0) && (m_idx < 4) && !resp_never[m_idx] && (m_wcnt >= resp_delay)) begin
            probe_ack   = 1'b1;
            probe_solid = resp_solid[m_idx];
        end else begin
            probe_ack   = 1'b0;
            probe_solid = 1'b0;
        end
    end

    // ---------------- observers ----------------
    logic [7:0] log_x[$];
    logic [7:0] log_y[$];
    int me_cnt, me_at, to_cnt, ov_cnt, u_held, tick_cyc;
    logic [7:0] u_y_watch;

    always @(negedge clock) begin
        if (probe_req && probe_ack) begin
            log_x.push_back(probe_x);
            log_y.push_back(probe_y);
        end
        if (move_enable) begin
            me_cnt++;
            me_at = cyc - tick_cyc;
        end
        if (timeout) to_cnt++;
        if (overrun) ov_cnt++;
        if (probe_req && (probe_y == u_y_watch)) u_held++;
    end

    task automatic clear_obs(input logic [7:0] watch);
        log_x.delete();
        log_y.delete();
        me_cnt = 0;
        me_at = -1;
        to_cnt = 0;
        ov_cnt = 0;
        u_held = 0;
        u_y_watch = watch;
    endtask

    task automatic set_resp(input int dly, input bit [3:0] solid_rudl, input bit [3:0] never_rudl);
        resp_delay = dly;
        for (int i = 0; i < 4; i++) begin
            resp_solid[i] = solid_rudl[i];
            resp_never[i] = never_rudl[i];
        end
    endtask

    // Drives a one-cycle tick (cycle 0) then scrambles the position inputs.
    task automatic tick_at(input logic [7:0] x, input logic [7:0] y);
        @(posedge clock); #1;
        x_position = x;
        y_position = y;
        frame_tick = 1'b1;
        tick_cyc   = cyc;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        x_position = ~x;
        y_position = ~y;
    endtask

    task automatic wait_me(input int target);
        int n;
        n = 0;
        while ((me_cnt < target) && (n < 300)) begin
            @(negedge clock); #1;
            n++;
        end
        if (me_cnt < target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_me: saw %0d move_enable pulses, needed %0d within 300 cycles", me_cnt, target);
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {down_blocked, up_blocked, left_blocked, right_blocked};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state",
              {40'd0, probe_req, flags(), move_enable, busy, overrun, timeout, probe_x, probe_y},
              {40'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        // Zero-wait, no collision.
        clear_obs(8'hFF);
        set_resp(0, 4'b0000, 4'b0000);
        tick_at(8'd72, 8'd60);
        wait_me(1);
        check("t1_me_cycle", 64'(me_at), 64'd6);
        check("t1_me_count", 64'(me_cnt), 64'd1);
        check("t1_probe_count", 64'(log_x.size()), 64'd4);
        check("t1_coords", {log_x[0], log_y[0], log_x[1], log_y[1], log_x[2], log_y[2], log_x[3], log_y[3]},
              64'h4C4C_4C3B_4744_5044);
        check("t1_flags", 64'(flags()), 64'h0);

        // Mixed results, 3 wait cycles per probe. solid bits: [0]=D,[1]=U,[2]=L,[3]=R.
        clear_obs(8'hFF);
        set_resp(3, 4'b0101, 4'b0000);
        tick_at(8'd72, 8'd60);
        wait_me(1);
        check("t2_me_cycle", 64'(me_at), 64'd18);
        check("t2_flags", 64'(flags()), 64'b1010);
        check("t2_timeouts", 64'(to_cnt), 64'd0);

        // Wrap-around coordinates.
        clear_obs(8'hFF);
        set_resp(0, 4'b0000, 4'b0000);
        tick_at(8'd0, 8'd250);
        wait_me(1);
        check("t3_L_x", 64'(log_x[2]), 64'd255);
        check("t3_D_y", 64'(log_y[0]), 64'd10);
        check("t3_U_y", 64'(log_y[1]), 64'd249);
        check("t3_R_x", 64'(log_x[3]), 64'd8);

        // Timeout on the U probe.
        clear_obs(8'd59);
        set_resp(0, 4'b0000, 4'b0010);
        tick_at(8'd72, 8'd60);
        wait_me(1);
        check("t4_u_held", 64'(u_held), 64'd15);
        check("t4_timeout_pulses", 64'(to_cnt), 64'd1);
        check("t4_me_count", 64'(me_cnt), 64'd1);
        check("t4_me_cycle", 64'(me_at), 64'd20);
        check("t4_flags", 64'(flags()), 64'b0100);
        check("t4_acks", 64'(log_x.size()), 64'd3);

        // Overrun tick at cycle 3, back-to-back accepted tick at cycle 6.
        clear_obs(8'hFF);
        set_resp(0, 4'b0000, 4'b0000);
        tick_at(8'd10, 8'd20);                       // cycles 0,1
        @(posedge clock); #1;                        // cycle 2
        @(posedge clock); #1;                        // cycle 3
        frame_tick = 1'b1; x_position = 8'd200; y_position = 8'd200;
        @(posedge clock); #1;                        // cycle 4
        frame_tick = 1'b0;
        check("t5_overrun_c4", 64'(overrun), 64'd1);
        @(posedge clock); #1;                        // cycle 5
        check("t5_overrun_c5", 64'(overrun), 64'd0);
        @(posedge clock); #1;                        // cycle 6
        check("t5_me_c6", 64'(move_enable), 64'd1);
        frame_tick = 1'b1; x_position = 8'd30; y_position = 8'd40;
        @(posedge clock); #1;                        // cycle 7
        frame_tick = 1'b0;
        check("t5_restart_c7", {48'd0, busy, probe_req, 6'd0, probe_y}, {48'd0, 1'b1, 1'b1, 6'd0, 8'd56});
        wait_me(2);
        check("t5_overrun_count", 64'(ov_cnt), 64'd1);
        check("t5_me_count", 64'(me_cnt), 64'd2);

        // Reset asserted while the L probe is outstanding.
        clear_obs(8'hFF);
        set_resp(0, 4'b0101, 4'b0000);
        tick_at(8'd72, 8'd60);                       // cycles 0,1
        @(posedge clock); #1;                        // cycle 2
        @(posedge clock); #1;                        // cycle 3: PROBE_L
        check("t6_in_L", {48'd0, probe_req, 7'd0, probe_x}, {48'd0, 1'b1, 7'd0, 8'd71});
        resetn = 1'b0;
        #1;
        check("t6_reset_now", {56'd0, probe_req, busy, move_enable, 1'b0, flags()},
              {56'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111});
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("t6_no_me", 64'(me_cnt), 64'd0);
        check("t6_idle", {56'd0, probe_req, busy, 2'd0, flags()}, {56'd0, 1'b0, 1'b0, 2'd0, 4'b1111});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
